// File: rtl/slow_mem_model.sv
// Fixed-latency 128-bit line memory model; optional protocol
// checker enabled by defining SLOW_MEM_ERRCHK_EN.
module slow_mem_model #(
  parameter int LATENCY   = 5,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    READY
  } state_t;

  localparam logic [31:0] LAT_M1 = 32'(LATENCY - 1);

  logic [127:0] mem [0:MEM_DEPTH-1];

  state_t       state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [127:0] wdata_q, wdata_d;
  logic [127:0] rdata_q, rdata_d;
  logic         ready_q, ready_d;

  logic req;
  logic done;

  // Upper line-address bits only alias onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[27:IDX_W];

  assign req  = mem_read | mem_write;
  assign done = (state_q == BUSY) && (cnt_q == LAT_M1);

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;

  // Next-state, latch and completion logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = mem_write;
          idx_d   = mem_addr[IDX_W-1:0];
          wdata_d = mem_wdata;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        if (done) begin
          state_d = READY;
          ready_d = 1'b1;
          if (!we_q) rdata_d = mem[idx_q];
        end
      end
      READY: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Array write; not reset, and gated so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (rst_n && done && we_q) mem[idx_q] <= wdata_q;
  end

`ifdef SLOW_MEM_ERRCHK_EN
  logic [31:0] err_cnt;
  logic [27:0] addr_q;
  logic        lat_chk_q;
  logic        e_both, e_busy, e_lat;
  logic [31:0] err_inc;

  // Classify protocol violations seen this cycle.
  always_comb begin
    e_both  = (state_q == IDLE) && mem_read && mem_write;
    e_busy  = (state_q == BUSY) &&
              (!req || (mem_addr != addr_q) ||
               (mem_write != we_q));
    e_lat   = !lat_chk_q && (LATENCY < 1);
    err_inc = 32'(e_both) + 32'(e_busy) + 32'(e_lat);
  end

  // Count and report violations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      addr_q    <= '0;
      lat_chk_q <= 1'b0;
    end else begin
      lat_chk_q <= 1'b1;
      if (state_q == IDLE && req) addr_q <= mem_addr;
      err_cnt <= err_cnt + err_inc;
      if (e_both)
        $display("%0t slow_mem_model: read and write both high", $time);
      if (e_busy)
        $display("%0t slow_mem_model: request changed while busy", $time);
      if (e_lat)
        $display("%0t slow_mem_model: LATENCY below 1", $time);
    end
  end
`endif

endmodule

// File: tb/tb_slow_mem_model.sv
// Scoreboard bench for slow_mem_model: latency, data,
// wrap, back-to-back, mid-operation reset and dual request.
module tb_slow_mem_model;

  localparam int LAT = 5;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  slow_mem_model #(
    .LATENCY  (LAT),
    .MEM_DEPTH(256),
    .IDX_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct {
    int unsigned  cyc;
    logic [127:0] d;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mdl [0:255];
  logic [127:0] last_rd;
  int unsigned  cyc;
  int           checks;
  int           errors;
  logic         prev_rdy;

  localparam logic [127:0] W1  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_CDEF;
  localparam logic [127:0] W2  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] W3  = 128'hCAFE_F00D_ABCD_0123_4567_89AB_CDEF_7777;
  localparam logic [127:0] OLD = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
  localparam logic [127:0] NEW = 128'h5EED_5EED_5EED_5EED_5EED_5EED_5EED_5EED;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_ready) begin
      if (prev_rdy) chk("pulse_width", 1, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", 128'(cyc), 128'(e.cyc));
        chk("rdata", mem_rdata, e.d);
      end
    end
    prev_rdy = mem_ready;
  end

  // Caller is at #1 after an edge; request is accepted next edge.
  task automatic xact(input logic rd, input logic wr,
                      input logic [27:0] a, input logic [127:0] wd,
                      input logic [127:0] exp_rd);
    exp_t e;
    int n;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = wd;
    e.cyc = cyc + 1 + LAT;
    e.d   = exp_rd;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 40);
    if (!mem_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [27:0] a);
    last_rd = mdl[a[7:0]];
    xact(1'b1, 1'b0, a, '0, last_rd);
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d);
    mdl[a[7:0]] = d;
    xact(1'b0, 1'b1, a, d, last_rd);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    prev_rdy  = 1'b0;
    last_rd   = '0;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dut.mem[3] = 128'hA5A5;
    mdl[3]     = 128'hA5A5;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_ready", 128'(mem_ready), 0);
      chk("rst_rdata", mem_rdata, 0);
    end
    chk("rst_mem_kept", dut.mem[3], 128'hA5A5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    rd(28'h3);

    wr(28'h10, W1);
    rd(28'h10);

    wr(28'h105, W2);
    chk("wrap_mem5", dut.mem[5], W2);
    rd(28'h5);

    wr(28'h7, W3);
    chk("wr_keeps_rdata", mem_rdata, W2);

    wr(28'h20, OLD);
    mem_write = 1'b1;
    mem_addr  = 28'h20;
    mem_wdata = NEW;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_ready", 128'(mem_ready), 0);
    end
    mem_write = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_mem_kept", dut.mem[32], OLD);
    chk("abort_rdata_clr", mem_rdata, 0);
    last_rd = '0;
    rd(28'h20);

    mdl[9] = W3 ^ W1;
    xact(1'b1, 1'b1, 28'h9, W3 ^ W1, last_rd);
`ifdef SLOW_MEM_ERRCHK_EN
    chk("err_cnt", 128'(dut.err_cnt), 1);
`endif
    rd(28'h9);
    rd(28'h10);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", 128'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1);
  end

endmodule
